seven_seg_scan: RTL

SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

---
 rtl/seven_seg_scan.sv | 136 +++++++++++++
 1 files changed

// File: rtl/seven_seg_scan.sv
// Eight-digit multiplexed seven-segment scanner with frame-synchronous data commit.
// Define SEVSEG_BLANKING_EN to blank the anodes for the first 16 cycles of each digit slot.
module seven_seg_scan #(
  parameter int CLK_FREQ = 100,
  parameter int SCAN_US  = 1000
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [31:0] digits,
  input  logic [7:0]  dp_en,
  input  logic [7:0]  digit_en,
  input  logic        load,
  output logic        pending,
  output logic        frame_done,
  output logic [7:0]  AN,
  output logic [7:0]  cathodes
);

  localparam int DWELL = CLK_FREQ * SCAN_US;
  localparam int CW    = $clog2(DWELL);

  if (DWELL < 32) begin : g_dwell_check
    $error("seven_seg_scan: CLK_FREQ*SCAN_US must be at least 32");
  end

  typedef struct packed {
    logic [31:0] digits;
    logic [7:0]  dp_en;
    logic [7:0]  digit_en;
  } frame_t;

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic          slot_end;
  logic          wrap;
  frame_t        load_d;
  frame_t        pend_q;
  frame_t        disp_q;

  logic [3:0]    nib;
  logic [6:0]    seg;
  logic          lit;
  logic          blank;
  logic [7:0]    an_d;
  logic [7:0]    cath_d;

  assign load_d   = {digits, dp_en, digit_en};
  assign slot_end = (cnt == CW'(DWELL - 1));
  assign wrap     = slot_end && (idx == 3'd7);

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // sample the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_sys or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      idx        <= 3'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (slot_end) begin
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // NOTE: the pending and display registers are plain flops, not a RAM, so they
  // take the async reset; a display that comes up dark depends on it.
  always_ff @(posedge clk_sys or negedge rst) begin
    if (!rst) begin
      pend_q  <= '0;
      disp_q  <= '0;
      pending <= 1'b0;
    end else if (wrap) begin
      // A load landing on the wrap itself bypasses the pending register.
      if (load)         disp_q <= load_d;
      else if (pending) disp_q <= pend_q;
      pending <= 1'b0;
    end else if (load) begin
      pend_q  <= load_d;
      pending <= 1'b1;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    nib = disp_q.digits[{idx, 2'b00} +: 4];
    seg = 7'b1111111;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase

`ifdef SEVSEG_BLANKING_EN
    blank = (cnt < CW'(16));
`else
    blank = 1'b0;
`endif

    lit    = disp_q.digit_en[idx];
    an_d   = 8'hFF;
    cath_d = 8'hFF;
    if (lit) begin
      cath_d = {~disp_q.dp_en[idx], seg};
      if (!blank) an_d = ~(8'b0000_0001 << idx);
    end
  end

  always_ff @(posedge clk_sys or negedge rst) begin
    if (!rst) begin
      AN       <= 8'hFF;
      cathodes <= 8'hFF;
    end else begin
      AN       <= an_d;
      cathodes <= cath_d;
    end
  end

endmodule
